ngv_pwm_gen: RTL

Multi-channel programmable PWM and blinker generator driving complementary output pairs (`out_p`/`out_n`) from the PLL core clock. It generalises the fixed divide-by-N complementary toggler. Each channel has a runtime period, a compare (duty) value and a dead-time. New settings are double-buffered and take effect only at the period boundary. It sits directly behind the core PLL and feeds pad-level outputs (LEDs, gate drivers).

---
 rtl/ngv_pwm_pkg.sv | 16 +
 rtl/ngv_pwm_chan.sv | 96 +++++++++
 rtl/ngv_pwm_gen.sv | 57 +++++
 3 files changed

// File: rtl/ngv_pwm_pkg.sv
// ngv_pwm_pkg
// Shared definitions for the ngv_pwm_gen PWM/blinker block.
//   SEL_*     : wr_sel encodings for the per-channel shadow registers.
//   ch_w()    : width of the channel-select field (at least one bit).
package ngv_pwm_pkg;

  localparam logic [1:0] SEL_PER  = 2'd0;
  localparam logic [1:0] SEL_CMP  = 2'd1;
  localparam logic [1:0] SEL_DT   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/ngv_pwm_chan.sv
// ngv_pwm_chan
// One PWM channel: shadow/active settings, period counter, dead-time
// counter and the registered phase that drives the complementary pair.
// Ports:
//   clk, rst      : core clock, asynchronous active-low reset
//   en            : run enable (low freezes counter/actives, blanks outputs)
//   wr_stb        : write strobe already decoded for this channel
//   wr_sel        : which shadow register to write
//   wr_data       : write data (dead-time uses the low DTW bits)
//   out_p, out_n  : complementary outputs, never high together
//   wrap          : one-cycle pulse in the last cycle of each period
module ngv_pwm_chan
  import ngv_pwm_pkg::*;
#(
  parameter int CW  = 32,
  parameter int DTW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           wr_stb,
  input  logic [1:0]     wr_sel,
  input  logic [CW-1:0]  wr_data,
  output logic           out_p,
  output logic           out_n,
  output logic           wrap
);

  logic [CW-1:0]  per_s_q, cmp_s_q, per_a_q, cmp_a_q;
  logic [DTW-1:0] dt_s_q, dt_a_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DTW-1:0] dtc_q, dtc_d;
  logic           raw_q, raw_d;
  logic           running, at_end, load_act, gate;

  always_comb begin
    running  = (per_a_q != '0);
    at_end   = running && (cnt_q == per_a_q);
    // Idle channels present a low phase so the first real period starts
    // cleanly from cnt == 0 instead of inheriting a stale high phase.
    raw_d    = running && (cnt_q < cmp_a_q);
    // Actives reload at every period boundary, and continuously while idle
    // so a freshly written period starts without waiting for a wrap.
    load_act = en && (!running || at_end);

    cnt_d = cnt_q;
    if (en) begin
      if (load_act) cnt_d = '0;
      else          cnt_d = cnt_q + CW'(1);
    end

    // Disabled channels keep the dead-time armed so re-enable starts blanked.
    dtc_d = dtc_q;
    if (!en)                  dtc_d = dt_a_q;
    else if (raw_d != raw_q)  dtc_d = dt_a_q;
    else if (dtc_q != '0)     dtc_d = dtc_q - DTW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_s_q <= '0;
      cmp_s_q <= '0;
      dt_s_q  <= '0;
      per_a_q <= '0;
      cmp_a_q <= '0;
      dt_a_q  <= '0;
      cnt_q   <= '0;
      dtc_q   <= '0;
      raw_q   <= 1'b0;
    end else begin
      // The active copy samples the pre-write shadow on a same-edge write.
      if (load_act) begin
        per_a_q <= per_s_q;
        cmp_a_q <= cmp_s_q;
        dt_a_q  <= dt_s_q;
      end
      if (wr_stb) begin
        case (wr_sel)
          SEL_PER: per_s_q <= wr_data;
          SEL_CMP: cmp_s_q <= wr_data;
          SEL_DT:  dt_s_q  <= wr_data[DTW-1:0];
          default: ;
        endcase
      end
      cnt_q <= cnt_d;
      dtc_q <= dtc_d;
      raw_q <= raw_d;
    end
  end

  assign gate  = en && running && (dtc_q == '0);
  assign out_p = gate &&  raw_q;
  assign out_n = gate && !raw_q;
  assign wrap  = en && at_end;

endmodule

// File: rtl/ngv_pwm_gen.sv
// ngv_pwm_gen
// Multi-channel complementary PWM / blinker generator. Decodes register
// writes to one of CH channels and fans out the global enable.
// Ports:
//   clk, rst      : core clock, asynchronous active-low reset
//   en            : global run enable
//   wr_en         : one-cycle write strobe
//   wr_ch         : target channel (values >= CH are ignored)
//   wr_sel        : 0 period, 1 compare, 2 dead-time, 3 ignored
//   wr_data       : write data
//   out_p, out_n  : per-channel complementary outputs
//   wrap          : per-channel period-boundary pulse
module ngv_pwm_gen
  import ngv_pwm_pkg::*;
#(
  parameter int CH  = 4,
  parameter int CW  = 32,
  parameter int DTW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [ch_w(CH)-1:0]   wr_ch,
  input  logic [1:0]            wr_sel,
  input  logic [CW-1:0]         wr_data,
  output logic [CH-1:0]         out_p,
  output logic [CH-1:0]         out_n,
  output logic [CH-1:0]         wrap
);

  localparam int CHW = ch_w(CH);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic wr_stb;
      // Out-of-range channel numbers never match any gi, so they drop out here.
      assign wr_stb = wr_en && (wr_ch == CHW'(gi)) && (wr_sel != SEL_NONE);

      ngv_pwm_chan #(
        .CW  (CW),
        .DTW (DTW)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_stb  (wr_stb),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .out_p   (out_p[gi]),
        .out_n   (out_n[gi]),
        .wrap    (wrap[gi])
      );
    end
  endgenerate

endmodule
